// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_pkg
//  Description : Shared definitions for the pipelined adder/subtractor:
//                operation encodings for the 'sub' input and the parameter
//                legality check (WIDTH must split evenly into STAGES slices).
//  Revision    : 1.0  initial release
// ============================================================================
package pipelined_adder_pkg;

    // Encoding of the 'sub' input
    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    // True when the carry chain can be cut into equal non-empty slices
    function automatic bit split_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage : pipelined_adder_pkg
`default_nettype wire

// File: rtl/pipelined_adder_slice.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_slice
//  Description : Combinational CHUNK-bit ripple slice of the pipelined adder.
//  Ports       : a, b  - CHUNK-bit operand slices
//                cin   - carry into the slice LSB
//                sum   - CHUNK-bit slice result
//                cout  - carry out of the slice MSB
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] w_total;

    // One bit wider than the slice so the carry falls out as the MSB
    assign w_total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum     = w_total[CHUNK-1:0];
    assign cout    = w_total[CHUNK];

endmodule : pipelined_adder_slice
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : WIDTH-bit adder/subtractor whose carry chain is cut into
//                STAGES registered slices. One beat per cycle, latency STAGES,
//                valid/ready handshake on both sides with a global stall.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                in_valid / in_ready   - input handshake (in_ready is
//                                        combinational from out_ready)
//                a, b, c_in, sub       - operands, carry-in, 0:add 1:subtract
//                out_valid / out_ready - output handshake
//                sum, carry_out,       - registered result, MSB carry
//                overflow                (sub: 1 = no borrow), signed overflow
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    // Per-stage registers. Every stage carries the full operands and the
    // partial sum so that the last stage register doubles as the output
    // register; bits already consumed are simply not read downstream.
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    // Inputs seen by each stage and the values it would register
    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic             w_c_in  [STAGES];
    logic             w_v_in  [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_c_nxt [STAGES];

    logic             w_adv;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
    logic             w_ovf_nxt;

    // The whole pipeline moves only when the output slot is free or drained
    assign w_adv    = ~r_v[STAGES-1] | out_ready;
    assign in_ready = w_adv;

    // Subtraction is a + ~b + 1; c_in is ignored in that mode
    assign w_b0 = (sub == ADD_OP) ? b : ~b;
    assign w_c0 = (sub == SUB_OP) ? 1'b1 : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_chunk;
        logic [WIDTH-1:0] w_s_k;

        if (k == 0) begin : g_src_port
            assign w_a_in[k] = a;
            assign w_b_in[k] = w_b0;
            assign w_s_in[k] = '0;
            assign w_c_in[k] = w_c0;
            assign w_v_in[k] = in_valid;
        end else begin : g_src_prev
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_s_in[k] = r_s[k-1];
            assign w_c_in[k] = r_c[k-1];
            assign w_v_in[k] = r_v[k-1];
        end

        pipelined_adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a    (w_a_in[k][k*CHUNK +: CHUNK]),
            .b    (w_b_in[k][k*CHUNK +: CHUNK]),
            .cin  (w_c_in[k]),
            .sum  (w_chunk),
            .cout (w_c_nxt[k])
        );

        // Completed lower bits ride along; this stage fills in its own chunk
        always_comb begin
            w_s_k                   = w_s_in[k];
            w_s_k[k*CHUNK +: CHUNK] = w_chunk;
        end
        assign w_s_nxt[k] = w_s_k;
    end

    // Signed overflow from the MSBs of a, b' (already inverted for subtract)
    // and the final sum, evaluated where the last slice completes
    assign w_ovf_nxt = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1]) &&
                       (w_s_nxt[STAGES-1][WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_in[k];
                // Bubbles leave datapath registers untouched so the outputs
                // hold their last value while out_valid is low
                if (w_v_in[k]) begin
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                    r_s[k] <= w_s_nxt[k];
                    r_c[k] <= w_c_nxt[k];
                end
            end
            if (w_v_in[STAGES-1]) begin
                r_ovf <= w_ovf_nxt;
            end
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign carry_out = r_c[STAGES-1];
    assign overflow  = r_ovf;

endmodule : pipelined_adder
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
//                Directed scenarios followed by random traffic, all checked
//                against an arithmetic reference model with a beat queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        int               due;
    } beat_t;

    beat_t q[$];
    beat_t last_shown;
    int    adv_cnt;
    int    checks;
    int    errors;

    // Reference: plain integer arithmetic on the operand values
    function automatic beat_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                    input logic mc, input logic ms);
        beat_t r;
        int    ua, ub, sa, sb, ures, sres;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            ures = ua - ub;
            sres = sa - sb;
            r.co = (ua >= ub);
        end else begin
            ures = ua + ub + int'(mc);
            sres = sa + sb + int'(mc);
            r.co = (ures >= 65536);
        end
        r.s   = ures[WIDTH-1:0];
        r.ov  = (sres > 32767) || (sres < -32768);
        r.due = 0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model,
    // update the model with whatever the handshake transfers at the edge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ic, input logic is, input logic ordy);
        logic  exp_ov;
        logic  exp_rdy;
        beat_t nb;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        c_in      = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        exp_ov  = (q.size() > 0) && (q[0].due <= adv_cnt);
        exp_rdy = !exp_ov || ordy;
        check("out_valid", out_valid, exp_ov);
        check("in_ready", in_ready, exp_rdy);
        if (exp_ov) begin
            check("sum", sum, q[0].s);
            check("carry_out", carry_out, q[0].co);
            check("overflow", overflow, q[0].ov);
        end else begin
            check("hold_sum", sum, last_shown.s);
            check("hold_carry", carry_out, last_shown.co);
            check("hold_ovf", overflow, last_shown.ov);
        end
        if (exp_ov && ordy) begin
            last_shown = q.pop_front();
        end
        if (exp_rdy) begin
            adv_cnt++;
            if (iv) begin
                nb     = model(ia, ib, ic, is);
                nb.due = adv_cnt + STAGES - 1;
                q.push_back(nb);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        q.delete();
        last_shown = '{s: '0, co: 1'b0, ov: 1'b0, due: 0};
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        check(tag, q.size(), 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        adv_cnt    = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        c_in       = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        last_shown = '{s: '0, co: 1'b0, ov: 1'b0, due: 0};

        // Reset for two cycles; first step checks the cleared outputs
        do_reset(2);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Wrap-around add, signed-overflowing subtract, borrowing subtract
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1);
        drain("drain_directed");

        // Eight back-to-back beats
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(i), 16'(16'h1000 * i), 1'b0, 1'b0, 1'b1);
        end
        drain("drain_b2b");

        // Fill with out_ready low, stall, then release
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 16'(16'h0111 * i), 16'hF00F, 1'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h7FFF, 16'(i), 1'b1, 1'b0, 1'b1);
        end
        drain("drain_stall");

        // Three beats in flight, one-cycle reset, then a fresh beat
        step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h2345, 16'h1111, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h3456, 16'h1111, 1'b0, 1'b0, 1'b1);
        do_reset(1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        check("drain_after_reset", q.size(), 0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipelined_adder
`default_nettype wire
